// File: rtl/assoc_cache_pkg.sv
// ============================================================================
// cache_pkg : shared FSM state type and geometry-derived field widths
// Rev 1.0
// ============================================================================
`default_nettype none

package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_MISS   = 2'd2
  } state_e;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets, input int line_words);
    return addr_w - $clog2(sets) - $clog2(line_words);
  endfunction

  // A direct-mapped instance still carries a one-bit age/way field.
  function automatic int age_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/assoc_cache_lru_ages.sv
// ============================================================================
// lru_ages : per-set true-LRU age array with combinational victim select
// Rev 1.0
// ============================================================================
`default_nettype none

module lru_ages #(
  parameter int SETS  = 16,
  parameter int WAYS  = 2,
  parameter int IDX_W = 4,
  parameter int AGE_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             upd_i,
  input  logic [IDX_W-1:0] set_i,
  input  logic [AGE_W-1:0] way_i,
  input  logic [WAYS-1:0]  valid_i,
  output logic [AGE_W-1:0] victim_o
);

  logic [AGE_W-1:0] ages_q [SETS][WAYS];
  logic [AGE_W-1:0] w_oldAge;

  assign w_oldAge = ages_q[set_i][way_i];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          ages_q[s][w] <= AGE_W'(w);
    end else if (clear_i) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          ages_q[s][w] <= AGE_W'(w);
    end else if (upd_i) begin
      // Accessed way becomes MRU; only the ways younger than it age by one.
      for (int w = 0; w < WAYS; w++) begin
        if (AGE_W'(w) == way_i)
          ages_q[set_i][w] <= '0;
        else if (ages_q[set_i][w] < w_oldAge)
          ages_q[set_i][w] <= ages_q[set_i][w] + 1'b1;
      end
    end
  end

  always_comb begin
    victim_o = '0;
    for (int w = 0; w < WAYS; w++)
      if (ages_q[set_i][w] == AGE_W'(WAYS - 1))
        victim_o = AGE_W'(w);
    // Descending scan so the lowest-index invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_i[w])
        victim_o = AGE_W'(w);
  end

endmodule

`default_nettype wire

// File: rtl/assoc_cache.sv
// ============================================================================
// assoc_cache : N-way set-associative read cache, true-LRU, line refill, flush
// Rev 1.0
// ============================================================================
`default_nettype none

module assoc_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int WORD_W     = 16,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16,
  parameter int WAYS       = 2,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         reqValid,
  input  logic [ADDR_W-1:0]            reqAddr,
  output logic                         reqReady,
  output logic                         respValid,
  output logic [WORD_W-1:0]            respData,
  output logic                         memReqValid,
  output logic [ADDR_W-1:0]            memReqAddr,
  input  logic                         memRespValid,
  input  logic [LINE_WORDS*WORD_W-1:0] memRespData,
  input  logic                         flush,
  output logic [CNT_W-1:0]             hitCount,
  output logic [CNT_W-1:0]             missCount
);

  localparam int OFF_W  = off_w(LINE_WORDS);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_WORDS);
  localparam int AGE_W  = age_w(WAYS);
  localparam int LINE_W = LINE_WORDS * WORD_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              flushPend_q, flushPend_d;
  logic              respValid_q;
  logic [WORD_W-1:0] respData_q;
  logic [CNT_W-1:0]  hitCount_q, missCount_q;
  logic [WAYS-1:0]   valid_q [SETS];
  logic [TAG_W-1:0]  tags_q  [SETS][WAYS];
  logic [LINE_W-1:0] lines_q [SETS][WAYS];

  logic [OFF_W-1:0]  w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [WAYS-1:0]   w_hitVec;
  logic [AGE_W-1:0]  w_hitWay, w_victim;
  logic              w_accept, w_flushExec, w_hit, w_miss, w_fill;

  // Word 0 occupies the most significant slot of a line.
  function automatic logic [WORD_W-1:0] pick(input logic [LINE_W-1:0] line,
                                             input logic [OFF_W-1:0]  off);
    return line[(LINE_WORDS - 1 - int'(off)) * WORD_W +: WORD_W];
  endfunction

  assign w_off = addr_q[OFF_W-1:0];
  assign w_idx = addr_q[OFF_W +: IDX_W];
  assign w_tag = addr_q[ADDR_W-1 -: TAG_W];

  always_comb begin
    w_hitVec = '0;
    w_hitWay = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_hitVec[w] = valid_q[w_idx][w] && (tags_q[w_idx][w] == w_tag);
      if (w_hitVec[w])
        w_hitWay = AGE_W'(w);
    end
  end

  always_comb begin
    state_d     = state_q;
    w_accept    = 1'b0;
    w_flushExec = 1'b0;
    w_hit       = 1'b0;
    w_miss      = 1'b0;
    w_fill      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flushPend_q) begin
          w_flushExec = 1'b1;
        end else if (reqValid) begin
          w_accept = 1'b1;
          state_d  = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (|w_hitVec) begin
          w_hit   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          w_miss  = 1'b1;
          state_d = ST_MISS;
        end
      end
      ST_MISS: begin
        if (memRespValid) begin
          w_fill  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    flushPend_d = flush | (flushPend_q & ~w_flushExec);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      flushPend_q <= 1'b0;
      respValid_q <= 1'b0;
      respData_q  <= '0;
      hitCount_q  <= '0;
      missCount_q <= '0;
      for (int s = 0; s < SETS; s++)
        valid_q[s] <= '0;
    end else begin
      state_q     <= state_d;
      flushPend_q <= flushPend_d;
      respValid_q <= w_hit | w_fill;
      if (w_accept)
        addr_q <= reqAddr;
      if (w_hit)
        respData_q <= pick(lines_q[w_idx][w_hitWay], w_off);
      else if (w_fill)
        respData_q <= pick(memRespData, w_off);
      if (w_hit && (hitCount_q != '1))
        hitCount_q <= hitCount_q + 1'b1;
      if (w_miss && (missCount_q != '1))
        missCount_q <= missCount_q + 1'b1;
      if (w_flushExec) begin
        for (int s = 0; s < SETS; s++)
          valid_q[s] <= '0;
      end else if (w_fill) begin
        valid_q[w_idx][w_victim] <= 1'b1;
      end
    end
  end

  // Tag and line storage is RAM-like and carries no reset; valid bits guard it.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      tags_q[w_idx][w_victim]  <= w_tag;
      lines_q[w_idx][w_victim] <= memRespData;
    end
  end

  lru_ages #(
    .SETS  (SETS),
    .WAYS  (WAYS),
    .IDX_W (IDX_W),
    .AGE_W (AGE_W)
  ) u_lru (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (w_flushExec),
    .upd_i    (w_hit | w_fill),
    .set_i    (w_idx),
    .way_i    (w_hit ? w_hitWay : w_victim),
    .valid_i  (valid_q[w_idx]),
    .victim_o (w_victim)
  );

  assign reqReady    = (state_q == ST_IDLE) && !flushPend_q;
  assign respValid   = respValid_q;
  assign respData    = respData_q;
  assign memReqValid = (state_q == ST_MISS);
  assign memReqAddr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign hitCount    = hitCount_q;
  assign missCount   = missCount_q;

endmodule

`default_nettype wire

// File: tb/tb_assoc_cache.sv
// ============================================================================
// tb_assoc_cache : directed bench for default geometry and a 4-way/8-set/8-word
// instance with 2-bit counters. Rev 1.0
// ============================================================================
`default_nettype none

module tb_assoc_cache;

  logic clk, rst;
  int   total, bad;

  // Default-geometry instance
  logic        reqValid, reqReady, respValid, memReqValid, memRespValid, flush;
  logic [15:0] reqAddr, respData, memReqAddr, hitCount, missCount;
  logic [63:0] memRespData;

  // WAYS=4, SETS=8, LINE_WORDS=8, CNT_W=2 instance
  logic         b_reqValid, b_reqReady, b_respValid, b_memReqValid, b_memRespValid, b_flush;
  logic [15:0]  b_reqAddr, b_respData, b_memReqAddr;
  logic [127:0] b_memRespData;
  logic [1:0]   b_hitCount, b_missCount;

  assoc_cache dut (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqAddr(reqAddr), .reqReady(reqReady),
    .respValid(respValid), .respData(respData),
    .memReqValid(memReqValid), .memReqAddr(memReqAddr),
    .memRespValid(memRespValid), .memRespData(memRespData),
    .flush(flush), .hitCount(hitCount), .missCount(missCount)
  );

  assoc_cache #(.ADDR_W(16), .WORD_W(16), .LINE_WORDS(8), .SETS(8), .WAYS(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .reqValid(b_reqValid), .reqAddr(b_reqAddr), .reqReady(b_reqReady),
    .respValid(b_respValid), .respData(b_respData),
    .memReqValid(b_memReqValid), .memReqAddr(b_memReqAddr),
    .memRespValid(b_memRespValid), .memRespData(b_memRespData),
    .flush(b_flush), .hitCount(b_hitCount), .missCount(b_missCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] mk_line(input logic [15:0] base);
    logic [127:0] l;
    for (int k = 0; k < 8; k++) l[(7 - k) * 16 +: 16] = base + 16'(k);
    return l;
  endfunction

  // One request on the default instance; memory answers dly cycles into MISS.
  // cyc = edges after the accepting edge until respValid is seen (-1: none).
  task automatic req_a(input logic [15:0] addr, input logic [63:0] line, input int dly,
                       output logic [15:0] data, output logic missed,
                       output logic [15:0] maddr, output int cyc);
    int n;
    n = 0; data = 'x; missed = 1'b0; maddr = 'x; cyc = -1;
    reqValid = 1'b1; reqAddr = addr;
    @(posedge clk); #1;
    reqValid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (respValid) begin data = respData; cyc = c; break; end
      if (memReqValid) begin
        missed = 1'b1; maddr = memReqAddr;
        memRespValid = (n == dly); memRespData = line; n++;
      end
      @(posedge clk); #1;
      memRespValid = 1'b0;
    end
  endtask

  task automatic req_b(input logic [15:0] addr, input logic [127:0] line, input int dly,
                       output logic [15:0] data, output logic missed,
                       output logic [15:0] maddr, output int cyc);
    int n;
    n = 0; data = 'x; missed = 1'b0; maddr = 'x; cyc = -1;
    b_reqValid = 1'b1; b_reqAddr = addr;
    @(posedge clk); #1;
    b_reqValid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (b_respValid) begin data = b_respData; cyc = c; break; end
      if (b_memReqValid) begin
        missed = 1'b1; maddr = b_memReqAddr;
        b_memRespValid = (n == dly); b_memRespData = line; n++;
      end
      @(posedge clk); #1;
      b_memRespValid = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    total++; if (reqReady !== 1'b1) begin bad++; $display("FAIL reset_reqReady got=%b exp=1", reqReady); end
    total++; if (respValid !== 1'b0 || respData !== 16'h0) begin bad++; $display("FAIL reset_resp got=%b/%h exp=0/0000", respValid, respData); end
    total++; if (memReqValid !== 1'b0 || memReqAddr !== 16'h0) begin bad++; $display("FAIL reset_mem got=%b/%h exp=0/0000", memReqValid, memReqAddr); end
    total++; if (hitCount !== 16'h0 || missCount !== 16'h0) begin bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", hitCount, missCount); end
    total++; if (b_reqReady !== 1'b1 || b_hitCount !== 2'd0 || b_missCount !== 2'd0) begin bad++; $display("FAIL reset_b got=%b/%0d/%0d exp=1/0/0", b_reqReady, b_hitCount, b_missCount); end
  endtask

  task automatic test_cold_miss;
    logic [15:0] d, ma; logic m; int cy;
    req_a(16'h0045, 64'h1111_2222_3333_4444, 0, d, m, ma, cy);
    total++; if (m !== 1'b1 || ma !== 16'h0044) begin bad++; $display("FAIL cold_memreq got=%b/%h exp=1/0044", m, ma); end
    total++; if (d !== 16'h2222) begin bad++; $display("FAIL cold_data got=%h exp=2222", d); end
    total++; if (cy !== 2) begin bad++; $display("FAIL cold_latency got=%0d exp=2", cy); end
    total++; if (missCount !== 16'd1 || hitCount !== 16'd0) begin bad++; $display("FAIL cold_counts got=%0d/%0d exp=0/1", hitCount, missCount); end
  endtask

  task automatic test_hit;
    logic [15:0] d, ma; logic m; int cy;
    req_a(16'h0047, 64'h0, 0, d, m, ma, cy);
    total++; if (m !== 1'b0) begin bad++; $display("FAIL hit_nomem got=%b exp=0", m); end
    total++; if (d !== 16'h4444) begin bad++; $display("FAIL hit_data got=%h exp=4444", d); end
    total++; if (cy !== 1) begin bad++; $display("FAIL hit_latency got=%0d exp=1", cy); end
    total++; if (hitCount !== 16'd1) begin bad++; $display("FAIL hit_count got=%0d exp=1", hitCount); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d, ma; logic m; int cy;
    total++; if (reqReady !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", reqReady); end
    req_a(16'h0044, 64'h0, 0, d, m, ma, cy);
    total++; if (m !== 1'b0 || d !== 16'h1111 || cy !== 1) begin bad++; $display("FAIL b2b_hit got=%b/%h/%0d exp=0/1111/1", m, d, cy); end
  endtask

  task automatic test_lru;
    logic [15:0] d, ma; logic m; int cy;
    req_a(16'h0084, 64'hB000_B001_B002_B003, 0, d, m, ma, cy);
    total++; if (m !== 1'b1 || d !== 16'hB000) begin bad++; $display("FAIL lru_fillB got=%b/%h exp=1/b000", m, d); end
    req_a(16'h0044, 64'h0, 0, d, m, ma, cy);
    total++; if (m !== 1'b0 || d !== 16'h1111) begin bad++; $display("FAIL lru_hitA got=%b/%h exp=0/1111", m, d); end
    req_a(16'h00C4, 64'hCCC0_CCC1_CCC2_CCC3, 2, d, m, ma, cy);
    total++; if (m !== 1'b1 || d !== 16'hCCC0 || cy !== 4) begin bad++; $display("FAIL lru_fillC got=%b/%h/%0d exp=1/ccc0/4", m, d, cy); end
    req_a(16'h0044, 64'h0, 0, d, m, ma, cy);
    total++; if (m !== 1'b0 || d !== 16'h1111) begin bad++; $display("FAIL lru_A_kept got=%b/%h exp=0/1111", m, d); end
    req_a(16'h0084, 64'hB000_B001_B002_B003, 0, d, m, ma, cy);
    total++; if (m !== 1'b1 || ma !== 16'h0084) begin bad++; $display("FAIL lru_B_evicted got=%b/%h exp=1/0084", m, ma); end
    total++; if (hitCount !== 16'd4 || missCount !== 16'd4) begin bad++; $display("FAIL lru_counts got=%0d/%0d exp=4/4", hitCount, missCount); end
  endtask

  task automatic test_flush;
    logic [15:0] d, ma; logic m; int cy;
    reqValid = 1'b1; reqAddr = 16'h0105;
    @(posedge clk); #1;
    reqValid = 1'b0;
    @(posedge clk); #1;
    total++; if (memReqValid !== 1'b1) begin bad++; $display("FAIL flush_inmiss got=%b exp=1", memReqValid); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; memRespValid = 1'b1; memRespData = 64'h5555_6666_7777_8888;
    @(posedge clk); #1;
    memRespValid = 1'b0;
    total++; if (respValid !== 1'b1 || respData !== 16'h6666) begin bad++; $display("FAIL flush_resp got=%b/%h exp=1/6666", respValid, respData); end
    total++; if (reqReady !== 1'b0) begin bad++; $display("FAIL flush_blocks_ready got=%b exp=0", reqReady); end
    @(posedge clk); #1;
    total++; if (reqReady !== 1'b1) begin bad++; $display("FAIL flush_ready_after got=%b exp=1", reqReady); end
    total++; if (hitCount !== 16'd4 || missCount !== 16'd5) begin bad++; $display("FAIL flush_counts_kept got=%0d/%0d exp=4/5", hitCount, missCount); end
    // 0x0087 was resident before the flush
    req_a(16'h0087, 64'hB000_B001_B002_B003, 0, d, m, ma, cy);
    total++; if (m !== 1'b1 || d !== 16'hB003) begin bad++; $display("FAIL flush_invalidated got=%b/%h exp=1/b003", m, d); end
    total++; if (missCount !== 16'd6) begin bad++; $display("FAIL flush_misscount got=%0d exp=6", missCount); end
  endtask

  task automatic test_reset_mid_miss;
    logic [15:0] d, ma; logic m; int cy; int seen;
    reqValid = 1'b1; reqAddr = 16'h0045;
    @(posedge clk); #1;
    reqValid = 1'b0;
    @(posedge clk); #1;
    total++; if (memReqValid !== 1'b1) begin bad++; $display("FAIL rmm_inmiss got=%b exp=1", memReqValid); end
    #2 rst = 1'b1;
    #1;
    total++; if (memReqValid !== 1'b0) begin bad++; $display("FAIL rmm_async_drop got=%b exp=0", memReqValid); end
    @(posedge clk); #1;
    rst = 1'b0;
    memRespValid = 1'b1; memRespData = 64'h1111_2222_3333_4444;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      memRespValid = 1'b0;
      if (respValid || memReqValid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rmm_late_resp got=%0d exp=0", seen); end
    total++; if (missCount !== 16'd0) begin bad++; $display("FAIL rmm_count_cleared got=%0d exp=0", missCount); end
    req_a(16'h0045, 64'h1111_2222_3333_4444, 0, d, m, ma, cy);
    total++; if (m !== 1'b1 || d !== 16'h2222) begin bad++; $display("FAIL rmm_still_invalid got=%b/%h exp=1/2222", m, d); end
  endtask

  task automatic test_params;
    logic [15:0] d, ma; logic m; int cy;
    req_b(16'h0040, mk_line(16'h0040), 1, d, m, ma, cy);
    total++; if (m !== 1'b1 || ma !== 16'h0040 || d !== 16'h0040 || cy !== 3) begin bad++; $display("FAIL p_fill1 got=%b/%h/%h/%0d exp=1/0040/0040/3", m, ma, d, cy); end
    req_b(16'h0080, mk_line(16'h0080), 0, d, m, ma, cy);
    req_b(16'h00C0, mk_line(16'h00C0), 0, d, m, ma, cy);
    total++; if (b_missCount !== 2'd3) begin bad++; $display("FAIL p_miss3 got=%0d exp=3", b_missCount); end
    req_b(16'h0100, mk_line(16'h0100), 0, d, m, ma, cy);
    total++; if (b_missCount !== 2'd3) begin bad++; $display("FAIL p_miss_sat got=%0d exp=3", b_missCount); end
    req_b(16'h0140, mk_line(16'h0140), 0, d, m, ma, cy);
    total++; if (m !== 1'b1 || d !== 16'h0140) begin bad++; $display("FAIL p_fill5 got=%b/%h exp=1/0140", m, d); end
    req_b(16'h0082, 128'h0, 0, d, m, ma, cy);
    total++; if (m !== 1'b0 || d !== 16'h0082) begin bad++; $display("FAIL p_hit_tag2 got=%b/%h exp=0/0082", m, d); end
    req_b(16'h0040, mk_line(16'h0040), 0, d, m, ma, cy);
    total++; if (m !== 1'b1 || ma !== 16'h0040) begin bad++; $display("FAIL p_oldest_evicted got=%b/%h exp=1/0040", m, ma); end
    for (int i = 0; i < 3; i++) req_b(16'h0082, 128'h0, 0, d, m, ma, cy);
    total++; if (b_hitCount !== 2'd3 || b_missCount !== 2'd3) begin bad++; $display("FAIL p_sat got=%0d/%0d exp=3/3", b_hitCount, b_missCount); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    reqValid = 1'b0; reqAddr = '0; memRespValid = 1'b0; memRespData = '0; flush = 1'b0;
    b_reqValid = 1'b0; b_reqAddr = '0; b_memRespValid = 1'b0; b_memRespData = '0; b_flush = 1'b0;
    test_reset;
    test_cold_miss;
    test_hit;
    test_back_to_back;
    test_lru;
    test_flush;
    test_reset_mid_miss;
    test_params;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/assoc_cache.md
# assoc_cache

Parametrised N-way set-associative read cache with true-LRU replacement, a valid/ready request port, a line-refill memory port, flush, and hit/miss statistics. It generalises the fixed 2-way, 16-set, 4-word instruction and data caches to configurable geometry. One instance sits between a core fetch or load port and `mem`. Hit latency is one cycle; misses refill a full line and then respond.

## Interface
- `ADDR_W`, 16: byte/word address width. Addresses are word-granular.
- `WORD_W`, 16: data word width.
- `LINE_WORDS`, 4: words per line. Power of 2, ≥2.
- `SETS`, 16: number of sets. Power of 2, ≥2.
- `WAYS`, 2: associativity. Power of 2, 1..8.
- `CNT_W`, 16: width of the statistics counters.
- `clk` in 1: clock. All state is updated on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `reqValid` in 1: read request present.
- `reqAddr` in ADDR_W: request word address.
- `reqReady` out 1: request accepted on an edge where `reqValid && reqReady`.
- `respValid` out 1: one-cycle pulse; `respData` is valid in that cycle.
- `respData` out WORD_W: requested word.
- `memReqValid` out 1: line fetch request. Held high until the response arrives.
- `memReqAddr` out ADDR_W: line-aligned address; the low offset bits are 0.
- `memRespValid` in 1: one-cycle pulse; the line is on `memRespData`.
- `memRespData` in LINE_WORDS*WORD_W: the fetched line. Word 0 is in the most significant slot.
- `flush` in 1: invalidate-all request (pulse).
- `hitCount` out CNT_W: saturating hit counter.
- `missCount` out CNT_W: saturating miss counter.

## Operation
- Address fields:
  - offset = `reqAddr[OFF_W-1:0]`
  - index = next `IDX_W` bits
  - tag = remaining `TAG_W = ADDR_W-IDX_W-OFF_W` bits
- Storage per way per set:
  - tag
  - line data
  - valid flop
  - age of `clog2(WAYS)` bits
- Within a set the ages are always a permutation of 0..WAYS-1. Age 0 is MRU.
- FSM states and transitions:
  - IDLE: `reqReady=1`. On accept, the address is registered → LOOKUP.
  - LOOKUP: compare all ways in parallel.
    - Hit: `respValid`/`respData` are registered, ages are updated, `hitCount`+1 → IDLE.
    - Miss: `missCount`+1 → MISS.
  - MISS: `memReqValid=1`, `memReqAddr` = registered address with the offset cleared. On `memRespValid`:
    - the victim way is written (tag, line, valid=1)
    - ages are updated
    - `respData` = the offset word from `memRespData`, `respValid` pulses next cycle
    - → IDLE
- Victim selection: the lowest-index invalid way; otherwise the way with age WAYS-1.
- Age update on access to way w with old age a: way w gets age 0; every way in the set with age < a gets +1; all other ages are unchanged.
- Flush:
  - `flush` sets a pending flag in any state.
  - The pending flush is executed in the next IDLE cycle: all valid bits are cleared in one cycle and ages reset to the way index.
  - `reqReady=0` in that cycle. Flush has priority over a simultaneous `reqValid`.
- Counters saturate at 2^CNT_W-1. Only reset clears them; flush does not.
- `memRespValid` outside MISS is ignored.

## Timing
- Reset values:
  - state IDLE
  - `reqReady=1`
  - `respValid=0`, `respData=0`
  - `memReqValid=0`, `memReqAddr=0`
  - `hitCount=0`, `missCount=0`
  - all valid bits 0, ages = way index, flush pending 0
- Hit: accept on edge E0; `respValid` is high in the cycle after E1.
- Miss: `memReqValid` rises after E1 and falls after the edge Em that samples `memRespValid`; `respValid` is high in the cycle after Em.
- Minimum miss latency: 3 edges when memory answers in the first MISS cycle.
- `reqReady` is low in LOOKUP and MISS and in the response-pulse cycle's preceding edge. At most one request is outstanding; back-to-back hits accept every 2 cycles.
- Reset mid-miss: return to IDLE immediately and drop `memReqValid`. A late `memRespValid` is ignored and the cache contents stay invalid.

## Structure
- `cache_pkg` holds:
  - the state enum (IDLE, LOOKUP, MISS)
  - the `clog2`-derived widths `OFF_W`, `IDX_W`, `TAG_W`, `AGE_W` as functions of the parameters
- Sub-module `lru_ages`:
  - per-set age array, reset, flush reset, update port (set, way)
  - combinational victim output given the valid vector
- Tag/data arrays and the FSM live in `assoc_cache`.

## Test plan
- Cold miss, defaults: request 0x0045 → `memReqAddr`=0x0044; respond with line 0x1111_2222_3333_4444 → `respData`=0x2222, `missCount`=1.
- Hit after fill: request 0x0047 → `respData`=0x4444 one cycle after E1, no `memReqValid`, `hitCount`=1.
- LRU eviction, set 1:
  - fill 0x0044 (A), fill 0x0084 (B), hit A, fill 0x00C4 → B evicted
  - then request 0x0084 misses and 0x0044 hits
- Flush raised during a MISS: executes in the first IDLE cycle with `reqReady=0`; a subsequent request to 0x0047 misses; the counters are retained.
- Reset mid-MISS, then `memRespValid` pulse: no `respValid`, `memReqValid`=0, the next 0x0045 request misses.
- WAYS=4, SETS=8, LINE_WORDS=8: five distinct tags in one set evict the oldest; counter saturation with CNT_W=2 holds at 3.
